// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding and sizing helpers.
package div_pkg;

  localparam int DIV_DATA_WIDTH = 32;

  // ABSA, ABSD, SGNQ and SGNR are only ever entered in the signed build.
  typedef enum logic [2:0] {
    st_idle = 3'd0,
    st_absa = 3'd1,
    st_absd = 3'd2,
    st_iter = 3'd3,
    st_fix  = 3'd4,
    st_sgnq = 3'd5,
    st_sgnr = 3'd6,
    st_done = 3'd7
  } div_state_e;

  function automatic int div_iters(input int width);
    return width;
  endfunction

  function automatic int div_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_addsub.sv
// DATA_WIDTH+1-bit add/subtract: 4-bit carry-lookahead blocks chained block to
// block, plus the top sign bit. Subtract is a + ~b + 1.
module div_addsub
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic [DATA_WIDTH:0] a,
  input  logic [DATA_WIDTH:0] b,
  input  logic                sub,
  output logic [DATA_WIDTH:0] sum
);

  localparam int NB = DATA_WIDTH / 4;

  logic [DATA_WIDTH:0]   bx;
  logic [DATA_WIDTH:0]   p;
  logic [DATA_WIDTH:0]   c;
  logic [DATA_WIDTH-1:0] g;

  assign bx   = b ^ {(DATA_WIDTH + 1){sub}};
  assign p    = a ^ bx;
  assign g    = a[DATA_WIDTH-1:0] & bx[DATA_WIDTH-1:0];
  assign c[0] = sub;

  // Each block resolves its four carries from its own g/p and the block carry-in.
  for (genvar blk = 0; blk < NB; blk++) begin : g_cla
    localparam int L = 4 * blk;
    assign c[L+1] = g[L]
                  | (p[L] & c[L]);
    assign c[L+2] = g[L+1]
                  | (p[L+1] & g[L])
                  | (p[L+1] & p[L] & c[L]);
    assign c[L+3] = g[L+2]
                  | (p[L+2] & g[L+1])
                  | (p[L+2] & p[L+1] & g[L])
                  | (p[L+2] & p[L+1] & p[L] & c[L]);
    assign c[L+4] = g[L+3]
                  | (p[L+3] & g[L+2])
                  | (p[L+3] & p[L+2] & g[L+1])
                  | (p[L+3] & p[L+2] & p[L+1] & g[L])
                  | (p[L+3] & p[L+2] & p[L+1] & p[L] & c[L]);
  end

  assign sum = p ^ c;

endmodule

// File: rtl/div_seq.sv
// Multi-cycle non-restoring divider, one quotient bit per clock through a shared adder.
// Define DIV_SIGNED_EN for two's-complement operands (adds ABSA/ABSD/SGNQ/SGNR).
module div_seq
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_zero
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = div_cnt_w(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(div_iters(W) - 1);
  localparam logic [W-1:0]     ALL_ONES = '1;

  div_state_e state, state_nxt;

  logic [W-1:0]     q_reg;   // dividend on entry, quotient bits shift in at [0]
  logic [W-1:0]     d_reg;
  logic [W:0]       p_reg;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       p_shift;
  logic [W:0]       add_a, add_b, add_sum;
  logic             add_sub;
`ifdef DIV_SIGNED_EN
  logic             neg_q, neg_r;
`endif

  assign p_shift = {p_reg[W-1:0], q_reg[W-1]};

  div_addsub #(.DATA_WIDTH(W)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= st_idle;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      st_idle: begin
        if (start) begin
          if (divisor == '0) state_nxt = st_done;
`ifdef DIV_SIGNED_EN
          else               state_nxt = st_absa;
`else
          else               state_nxt = st_iter;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      st_absa: state_nxt = st_absd;
      st_absd: state_nxt = st_iter;
      st_fix:  state_nxt = st_sgnq;
      st_sgnq: state_nxt = st_sgnr;
      st_sgnr: state_nxt = st_done;
`else
      st_fix:  state_nxt = st_done;
`endif
      st_iter: if (cnt == '0) state_nxt = st_fix;
      st_done: state_nxt = st_idle;
      default: state_nxt = st_idle;
    endcase
  end

  always_comb begin
    busy = 1'b1;
    done = 1'b0;
    case (state)
      st_idle: busy = 1'b0;
      st_done: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand steering for the single shared adder; the sign states compute 0 - x.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    case (state)
      st_iter: begin
        add_a   = p_shift;
        add_b   = {1'b0, d_reg};
        add_sub = ~p_reg[W];
      end
      st_fix: begin
        add_a = p_reg;
        add_b = {1'b0, d_reg};
      end
`ifdef DIV_SIGNED_EN
      st_absa: begin
        add_b   = {1'b0, q_reg};
        add_sub = 1'b1;
      end
      st_absd: begin
        add_b   = {1'b0, d_reg};
        add_sub = 1'b1;
      end
      st_sgnq: begin
        add_b   = {1'b0, quotient};
        add_sub = 1'b1;
      end
      st_sgnr: begin
        add_b   = {1'b0, remainder};
        add_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q_reg     <= '0;
      d_reg     <= '0;
      p_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        st_idle: begin
          if (start) begin
            q_reg     <= dividend;
            d_reg     <= divisor;
            p_reg     <= '0;
            cnt       <= CNT_LAST;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q     <= dividend[W-1] ^ divisor[W-1];
            neg_r     <= dividend[W-1];
`endif
            // Divide by zero bypasses the datapath and reports the raw dividend.
            if (divisor == '0) begin
              div_zero  <= 1'b1;
              quotient  <= ALL_ONES;
              remainder <= dividend;
            end
          end
        end
`ifdef DIV_SIGNED_EN
        st_absa: if (neg_r)       q_reg <= add_sum[W-1:0];
        st_absd: if (d_reg[W-1])  d_reg <= add_sum[W-1:0];
        st_sgnq: if (neg_q)       quotient  <= add_sum[W-1:0];
        st_sgnr: if (neg_r)       remainder <= add_sum[W-1:0];
`endif
        st_iter: begin
          p_reg <= add_sum;
          q_reg <= {q_reg[W-2:0], ~add_sum[W]};
          cnt   <= cnt - CNT_W'(1);
        end
        st_fix: begin
          // Final restore: a negative partial remainder gets the divisor added back.
          p_reg     <= p_reg[W] ? add_sum : p_reg;
          remainder <= p_reg[W] ? add_sum[W-1:0] : p_reg[W-1:0];
          quotient  <= q_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed boundary runs plus random operands
// against a plain-arithmetic reference model (follows DIV_SIGNED_EN if defined).
module tb_div_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  div_seq #(.DATA_WIDTH(32)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output int lat);
    dz = (d == 32'd0);
    if (dz) begin
      q   = 32'hFFFF_FFFF;
      r   = a;
      lat = 0;
    end else begin
`ifdef DIV_SIGNED_EN
      lat = 37;
      if (a == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(d);
        r = $signed(a) % $signed(d);
      end
`else
      lat = 33;
      q   = a / d;
      r   = a % d;
`endif
    end
  endfunction

  // One division; with hold set, start stays high (and operands wander) through DONE.
  task automatic run_div(input logic [31:0] a, input logic [31:0] d, input bit hold,
                         input string tag);
    logic [31:0] eq, er;
    logic        edz;
    int          elat;
    int          lat;
    model(a, d, eq, er, edz, elat);
    @(negedge clock);
    dividend = a;
    divisor  = d;
    start    = 1'b1;
    lat      = -1;
    for (int i = 0; i <= 60; i++) begin
      @(negedge clock);
      if (hold) begin
        dividend = ~a;
        divisor  = d + 32'd3;
      end else begin
        start = 1'b0;
      end
      if (i == 0 && elat != 0) check({tag, " busy"}, 64'(busy), 64'd1);
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " quotient"}, 64'(quotient), 64'(eq));
    check({tag, " remainder"}, 64'(remainder), 64'(er));
    check({tag, " div_zero"}, 64'(div_zero), 64'(edz));
    check({tag, " busy in done"}, 64'(busy), 64'd0);
    @(negedge clock);
    start = 1'b0;
    check({tag, " done pulse"}, 64'(done), 64'd0);
    check({tag, " idle busy"}, 64'(busy), 64'd0);
    check({tag, " quotient held"}, 64'(quotient), 64'(eq));
    check({tag, " remainder held"}, 64'(remainder), 64'(er));
  endtask

  initial begin
    logic [31:0] ra, rd;
    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clock);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset quotient", 64'(quotient), 64'd0);
    check("reset remainder", 64'(remainder), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    clear = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, "100/7");
    check("100/7 literal q", 64'(quotient), 64'd14);
    check("100/7 literal r", 64'(remainder), 64'd2);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "max/1");
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max/max");
    run_div(32'd1234, 32'd0, 1'b0, "1234/0");
    check("1234/0 literal q", 64'(quotient), 64'hFFFF_FFFF);
    check("1234/0 literal r", 64'(remainder), 64'd1234);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, "-7/2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "min/-1");
    run_div(32'd5, 32'hFFFF_FFFD, 1'b0, "5/-3");
    run_div(32'd3, 32'd9, 1'b0, "3/9");

    // Clear while results are held from a completed run.
    run_div(32'd77, 32'd0, 1'b0, "77/0");
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("clear held quotient", 64'(quotient), 64'd0);
    check("clear held remainder", 64'(remainder), 64'd0);
    check("clear held div_zero", 64'(div_zero), 64'd0);
    @(negedge clock);
    clear = 1'b0;

    // Clear in the middle of the iteration phase.
    @(negedge clock);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    check("pre-clear busy", 64'(busy), 64'd1);
    clear = 1'b1;
    #1;
    check("clear iter busy", 64'(busy), 64'd0);
    check("clear iter done", 64'(done), 64'd0);
    check("clear iter quotient", 64'(quotient), 64'd0);
    check("clear iter remainder", 64'(remainder), 64'd0);
    check("clear iter div_zero", 64'(div_zero), 64'd0);
    @(negedge clock);
    clear = 1'b0;

    run_div(32'd100, 32'd7, 1'b1, "held start 100/7");
    check("held literal q", 64'(quotient), 64'd14);
    check("held literal r", 64'(remainder), 64'd2);

    for (int n = 0; n < 20; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rd = $urandom;
        1:       rd = 32'($urandom_range(1, 255));
        2:       rd = 32'd0;
        default: rd = ra >> $urandom_range(0, 31);
      endcase
      run_div(ra, rd, 1'b0, $sformatf("rand%0d %h/%h", n, ra, rd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
